pattern_shift_gen: RTL and testbench
====================================

// Module: pattern_shift_gen
// PURPOSE
//  Parametrised successor to the fixed 16-bit pattern shifter used in the Shifters set.
//  Generates a WIDTH-bit shifting pattern selected at run time: rotate-left, rotate-right,
//  bounce, or Johnson. Adds a programmable step prescaler, enable, seed load, and
//  step/wrap strobes. Sits in front of LED/display or stimulus logic that consumes q.
// PARAMETERS
//  WIDTH      16      pattern width in bits, >= 2
//  DIV_W      8       prescaler divisor width
//  SEED_INIT  1       q value after reset (WIDTH bits, zero-extended)
//  TAPS       16'hB400 Galois LFSR feedback mask; used only with PATTERN_LFSR_EN
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      asynchronous reset, active-low (0 = reset)
//  en     in   1      advance enable; low = hold all state
//  mode   in   3      0 ROL, 1 ROR, 2 BOUNCE, 3 JOHNSON, 4 LFSR (optional), 5-7 reserved
//  div    in   DIV_W  pattern steps once every div+1 enabled cycles
//  load   in   1      synchronous seed load
//  seed   in   WIDTH  value loaded into q
//  q      out  WIDTH  current pattern
//  step   out  1      1-cycle pulse, high in the cycle q first shows a new value
//  wrap   out  1      1-cycle pulse with step when new q equals start value
// BEHAVIOUR
//  Reset (rst=0, async): q=SEED_INIT, start=SEED_INIT, cnt=0, dir=LEFT, step=0, wrap=0.
//  Priority each edge: load > en. With load=1: q<=seed, start<=seed, cnt<=0, dir<=LEFT,
//    step=0, wrap=0.
//  en=0 and load=0: q, cnt, dir held; step=0, wrap=0.
//  Prescaler: on each en cycle, if cnt==div then cnt<=0 and tick, else cnt<=cnt+1.
//    div=0 -> tick every en cycle. A div change takes effect at the next compare.
//    If cnt>div after a div change, cnt wraps through 2^DIV_W.
//  On tick, q updates on the same edge; step registered alongside (zero extra latency).
//  ROL:  q<={q[W-2:0],q[W-1]}.   ROR: q<={q[0],q[W-1:1]}.
//  JOHNSON: q<={q[W-2:0],~q[W-1]}. Period is 2W ticks from a one-hot or zero seed.
//  BOUNCE: dir FSM {LEFT,RIGHT}.
//    In LEFT: if q[W-1]=1 then dir<=RIGHT and q rotates right; else q rotates left.
//    In RIGHT: if q[0]=1 then dir<=LEFT and q rotates left; else q rotates right.
//    Period is 2W-2 ticks for a one-hot seed at bit 0.
//  wrap=1 iff tick and next q==start.
//  Mode change mid-run: applies at the next tick. dir and start are kept.
//  Reserved modes: q holds, step=0, wrap=0.
// CONFIGURATION
//  PATTERN_LFSR_EN defined: mode 4 = Galois LFSR, q<=(q>>1)^(q[0]?TAPS:0).
//    If q==0 at a tick, q<=SEED_INIT (lockup escape). wrap works as for other modes.
//  PATTERN_LFSR_EN undefined: mode 4 is reserved (hold), TAPS is unused, no LFSR logic.
// STRUCTURE
//  Package pattern_pkg holds the MODE_ROL..MODE_LFSR localparams and the DIR_LEFT/DIR_RIGHT
//    encodings.
//  Sub-module pattern_prescaler(clk,rst,en,clr,div -> tick) is the DIV_W counter; clr=load.
//  The top level holds the q/start/dir registers, next-pattern mux, and strobes.
// TESTING (WIDTH=16 unless noted)
//  1 rst=0 -> q=16'h0001, step=0, wrap=0 immediately. Then release, mode=0, div=0, en=1:
//    q 0002,0004,..,8000,0001; wrap=1 only on the 16th step.
//  2 div=3, mode=1: step every 4th cycle. en=0 for 5 cycles: q and cnt frozen,
//    step stays 0; sequence resumes at the same phase.
//  3 mode=2 from 0001: 0001..8000,4000..0001; wrap on the 30th step; dir flips at 8000/0001.
//  4 mode=3 from 0001: 0003,0007,..,FFFF,FFFE,..,8000,0000,0001; wrap on the 32nd step.
//  5 load=1 with seed=00F0 mid-run (cnt!=0): q=00F0 next edge, cnt=0, no step.
//    Then mode=1 gives 0078,003C,..; wrap at the 16th step.
//  6 rst pulsed low between edges mid-bounce -> q=0001, dir=LEFT at once.
//    With PATTERN_LFSR_EN, mode=4: load 0, then one tick gives q=0001.

Source files
------------

// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - mode and bounce-direction encodings for the pattern shift generator
package pattern_pkg;

  localparam logic [2:0] MODE_ROL     = 3'd0;
  localparam logic [2:0] MODE_ROR     = 3'd1;
  localparam logic [2:0] MODE_BOUNCE  = 3'd2;
  localparam logic [2:0] MODE_JOHNSON = 3'd3;
  localparam logic [2:0] MODE_LFSR    = 3'd4;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

endpackage

// File: rtl/pattern_prescaler.sv
// rtl/pattern_prescaler.sv - step prescaler: tick once every div+1 enabled cycles
module pattern_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // Equality compare, so a div lowered below cnt lets cnt wrap through 2^DIV_W.
  assign tick = en && !clr && (cnt == div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_shift_gen.sv
// rtl/pattern_shift_gen.sv - run-time selectable shifting pattern generator with step/wrap strobes
// Optional Galois LFSR mode 4 is built only when PATTERN_LFSR_EN is defined.
module pattern_shift_gen
  import pattern_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DIV_W     = 8,
  parameter logic [WIDTH-1:0] SEED_INIT = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q,
  output logic             step,
  output logic             wrap
);

  logic             tick;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] rol;
  logic [WIDTH-1:0] ror;
  logic             mode_ok;
  logic             bounce_right;
  dir_t             dir, dir_next;

  pattern_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .div  (div),
    .tick (tick)
  );

  assign rol = {q[WIDTH-2:0], q[WIDTH-1]};
  assign ror = {q[0], q[WIDTH-1:1]};

  // Bounce turns around on the edge bit itself, so each end is shown exactly once.
  assign bounce_right = (dir == DIR_LEFT) ? q[WIDTH-1] : !q[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir <= DIR_LEFT;
    end else if (load) begin
      dir <= DIR_LEFT;
    end else begin
      dir <= dir_next;
    end
  end

  always_comb begin
    dir_next = dir;
    if (tick && mode == MODE_BOUNCE) begin
      dir_next = bounce_right ? DIR_RIGHT : DIR_LEFT;
    end
  end

  always_comb begin
    q_next  = q;
    mode_ok = 1'b1;
    case (mode)
      MODE_ROL:     q_next = rol;
      MODE_ROR:     q_next = ror;
      MODE_BOUNCE:  q_next = bounce_right ? ror : rol;
      MODE_JOHNSON: q_next = {q[WIDTH-2:0], ~q[WIDTH-1]};
`ifdef PATTERN_LFSR_EN
      MODE_LFSR:    q_next = (q == '0) ? SEED_INIT : ((q >> 1) ^ (q[0] ? TAPS : '0));
`endif
      default:      mode_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q     <= SEED_INIT;
      start <= SEED_INIT;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else if (load) begin
      q     <= seed;
      start <= seed;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      step <= tick && mode_ok;
      wrap <= tick && mode_ok && (q_next == start);
      if (tick && mode_ok) begin
        q <= q_next;
      end
    end
  end

endmodule

// File: tb/tb_pattern_shift_gen.sv
// tb/tb_pattern_shift_gen.sv - scoreboard bench for pattern_shift_gen (LFSR case under PATTERN_LFSR_EN)
module tb_pattern_shift_gen;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        en   = 1'b0;
  logic        load = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [7:0]  div  = 8'd0;
  logic [15:0] seed = 16'd0;
  logic [15:0] q;
  logic        step;
  logic        wrap;

  typedef struct packed {
    logic [15:0] q;
    logic        wrap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  pattern_shift_gen dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .div  (div),
    .load (load),
    .seed (seed),
    .q    (q),
    .step (step),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] v, input logic w);
    exp_q.push_back({v, w});
  endtask

  task automatic wait_step(input int maxc, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!step && cnt <= maxc);
  endtask

  task automatic run_steps(input int n, input int period, input string name);
    int c;
    for (int i = 0; i < n; i++) begin
      wait_step(period + 2, c);
      check(name, c, period);
    end
  endtask

  // Monitor: every step pulse consumes one expected entry.
  always @(negedge clk) begin
    if (rst) begin
      if (step) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("step_q", q, mon_e.q);
          check("step_wrap", wrap, mon_e.wrap);
        end
      end else if (wrap) begin
        check("wrap_without_step", wrap, 0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t;
    logic [15:0] v;

    #1 rst = 1'b0;
    #1;
    check("reset_q", q, 16'h0001);
    check("reset_step", step, 0);
    check("reset_wrap", wrap, 0);

    // Rotate left, one step per cycle
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      t = 32'd1 << (i % 16);
      push(t[15:0], i == 16);
    end
    mode = 3'd0; div = 8'd0; en = 1'b1;
    run_steps(16, 1, "rol_period");

    // Rotate right with div=3, frozen mid-period by en=0
    v = 16'h0001;
    for (int i = 1; i <= 16; i++) begin
      v = {v[0], v[15:1]};
      push(v, i == 16);
    end
    mode = 3'd1; div = 8'd3;
    run_steps(2, 4, "ror_div3_period");
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_step", step, 0);
      check("hold_q", q, 16'h4000);
    end
    en = 1'b1;
    run_steps(1, 3, "resume_phase");
    run_steps(13, 4, "ror_div3_period");

    // Bounce from 0001
    for (int i = 1; i <= 30; i++) begin
      t = (i <= 15) ? (32'd1 << i) : (32'd1 << (30 - i));
      push(t[15:0], i == 30);
    end
    mode = 3'd2; div = 8'd0;
    run_steps(30, 1, "bounce_period");

    // Johnson from 0001
    for (int i = 1; i <= 32; i++) begin
      if (i <= 15)      t = (32'd1 << (i + 1)) - 32'd1;
      else if (i <= 31) t = 32'h0000FFFF << (i - 15);
      else              t = 32'd1;
      push(t[15:0], i == 32);
    end
    mode = 3'd3;
    run_steps(32, 1, "johnson_period");

    // Reserved mode holds
    mode = 3'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reserved_step", step, 0);
      check("reserved_q", q, 16'h0001);
    end

    // Seed load mid-count, then rotate right from the new start
    mode = 3'd0; div = 8'd3;
    repeat (2) @(negedge clk);
    load = 1'b1; seed = 16'h00F0;
    @(negedge clk);
    check("load_q", q, 16'h00F0);
    check("load_step", step, 0);
    load = 1'b0; mode = 3'd1;
    v = 16'h00F0;
    for (int i = 1; i <= 16; i++) begin
      v = {v[0], v[15:1]};
      push(v, i == 16);
    end
    run_steps(16, 4, "load_ror_period");

    // Async reset pulse between edges mid-bounce
    mode = 3'd2; div = 8'd0;
    push(16'h01E0, 1'b0);
    push(16'h03C0, 1'b0);
    run_steps(2, 1, "bounce_pre_reset");
    #2 rst = 1'b0;
    #1;
    check("async_rst_q", q, 16'h0001);
    check("async_rst_step", step, 0);
    check("async_rst_wrap", wrap, 0);
    #1 rst = 1'b1;
    push(16'h0002, 1'b0);
    push(16'h0004, 1'b0);
    run_steps(2, 1, "bounce_post_reset");
    en = 1'b0;

`ifdef PATTERN_LFSR_EN
    @(negedge clk);
    load = 1'b1; seed = 16'h0000; mode = 3'd4;
    @(negedge clk);
    load = 1'b0; en = 1'b1;
    push(16'h0001, 1'b0);
    run_steps(1, 1, "lfsr_lockup");
    en = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
